// File: rtl/sh_reg_pkg.sv
// Shared constants for the sh_reg AXI4-Lite shift/rotate peripheral:
// register map, CTRL field positions, response codes and engine states.
package sh_reg_pkg;

   localparam int CTRL_IDX    = 0;
   localparam int STATUS_IDX  = 1;
   localparam int DIN_IDX     = 2;
   localparam int DOUT_IDX    = 3;
   localparam int GP_BASE_IDX = 4;

   localparam int CTRL_START   = 0;
   localparam int CTRL_DIR     = 1;
   localparam int CTRL_ROT     = 2;
   localparam int CTRL_IE      = 3;
   localparam int CTRL_AMT_LSB = 8;
   localparam int CTRL_AMT_W   = 8;

   // Storable CTRL bits; start is a pulse and never held.
   localparam logic [15:0] CTRL_MASK = 16'hFF0E;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } sh_state_e;

endpackage

// File: rtl/sh_reg_shift_engine.sv
// Multi-cycle shift/rotate engine: one bit position per clock,
// operands latched at start so register writes cannot disturb a run.
module sh_reg_shift_engine #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] din,
   input  logic [7:0]    amt,
   input  logic          dir,
   input  logic          rot,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] dout
);
   import sh_reg_pkg::*;

   sh_state_e     state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [DW-1:0] dout_q, dout_d;
   logic [DW-1:0] step;
   logic          done_q, done_d;
   logic          dir_q, dir_d;
   logic          rot_q, rot_d;

   // A zero-amount run still spends one busy cycle in DONE before done sets.
   assign busy = (state_q == ST_SHIFT) ||
                 ((state_q == ST_DONE) && !done_q);
   assign done = done_q;
   assign dout = dout_q;

   always_comb begin
      step = dout_q;
      if (dir_q) begin
         step = rot_q ? {dout_q[0], dout_q[DW-1:1]}
                      : {1'b0, dout_q[DW-1:1]};
      end else begin
         step = rot_q ? {dout_q[DW-2:0], dout_q[DW-1]}
                      : {dout_q[DW-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      done_d  = done_q;
      dir_d   = dir_q;
      rot_d   = rot_q;
      unique case (state_q)
         ST_IDLE: begin
         end
         ST_SHIFT: begin
            dout_d = step;
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (start && !busy) begin
         dout_d  = din;
         cnt_d   = amt;
         done_d  = 1'b0;
         dir_d   = dir;
         rot_d   = rot;
         state_d = (amt == 8'd0) ? ST_DONE : ST_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
      end
   end

endmodule

// File: rtl/sh_reg_axil_shifter.sv
// AXI4-Lite register block wrapping the shift engine: CTRL, STATUS,
// DIN, DOUT and NUM_GP scratch registers with byte strobes.
module sh_reg_axil_shifter #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_GP             = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            irq
);
   import sh_reg_pkg::*;

   localparam int DW  = C_S_AXI_DATA_WIDTH;
   localparam int AW  = C_S_AXI_ADDR_WIDTH;
   localparam int SW  = DW / 8;
   localparam int ASB = (DW == 64) ? 3 : 2;
   localparam int IW  = AW - ASB;

   localparam logic [IW-1:0] I_CTRL   = IW'(CTRL_IDX);
   localparam logic [IW-1:0] I_STATUS = IW'(STATUS_IDX);
   localparam logic [IW-1:0] I_DIN    = IW'(DIN_IDX);
   localparam logic [IW-1:0] I_DOUT   = IW'(DOUT_IDX);

   logic          live_q, live_d;
   logic          aw_full_q, aw_full_d;
   logic [IW-1:0] aw_idx_q, aw_idx_d;
   logic          w_full_q, w_full_d;
   logic [DW-1:0] w_data_q, w_data_d;
   logic [SW-1:0] w_strb_q, w_strb_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q, bresp_d;
   logic          rvalid_q, rvalid_d;
   logic [1:0]    rresp_q, rresp_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] ctrl_q, ctrl_d;
   logic [DW-1:0] din_q, din_d;
   logic [DW-1:0] gp_q [NUM_GP];
   logic [DW-1:0] gp_d [NUM_GP];

   logic          eng_start, eng_busy, eng_done;
   logic [DW-1:0] eng_dout;
   logic [DW-1:0] wmask;
   logic          wr_exec, wr_gp_hit;
   logic [IW-1:0] rd_idx;
   logic [DW-1:0] rd_val, rd_gp_val;
   logic          rd_err, rd_gp_hit;
   logic          unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ASB-1:0],
                        S_AXI_ARADDR[ASB-1:0]};

   // live_q keeps every READY low while reset is held.
   assign S_AXI_AWREADY = live_q && !aw_full_q && !bvalid_q;
   assign S_AXI_WREADY  = live_q && !w_full_q && !bvalid_q;
   assign S_AXI_ARREADY = live_q && !rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign irq           = eng_done && ctrl_q[CTRL_IE];

   always_comb begin
      rd_idx    = S_AXI_ARADDR[AW-1:ASB];
      rd_gp_hit = 1'b0;
      rd_gp_val = '0;
      rd_val    = '0;
      rd_err    = 1'b0;
      for (int g = 0; g < NUM_GP; g++) begin
         if (rd_idx == IW'(GP_BASE_IDX + g)) begin
            rd_gp_hit = 1'b1;
            rd_gp_val = gp_q[g];
         end
      end
      unique case (1'b1)
         (rd_idx == I_CTRL):   rd_val = ctrl_q;
         (rd_idx == I_STATUS): rd_val = DW'({eng_done, eng_busy});
         (rd_idx == I_DIN):    rd_val = din_q;
         (rd_idx == I_DOUT):   rd_val = eng_dout;
         rd_gp_hit:            rd_val = rd_gp_val;
         default:              rd_err = 1'b1;
      endcase
   end

   always_comb begin
      live_d    = 1'b1;
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      ctrl_d    = ctrl_q;
      din_d     = din_q;
      gp_d      = gp_q;
      eng_start = 1'b0;
      wr_gp_hit = 1'b0;
      wmask     = '0;
      for (int b = 0; b < SW; b++) begin
         wmask[b*8 +: 8] = {8{w_strb_q[b]}};
      end

      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
         aw_full_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[AW-1:ASB];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
         w_full_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      // Holders stay full until the B handshake, so gate on !bvalid.
      wr_exec = aw_full_q && w_full_q && !bvalid_q;
      if (wr_exec) begin
         bvalid_d = 1'b1;
         bresp_d  = RESP_OKAY;
         for (int g = 0; g < NUM_GP; g++) begin
            if (aw_idx_q == IW'(GP_BASE_IDX + g)) begin
               wr_gp_hit = 1'b1;
               gp_d[g]   = (gp_q[g] & ~wmask) | (w_data_q & wmask);
            end
         end
         unique case (1'b1)
            (aw_idx_q == I_CTRL): begin
               ctrl_d = ((ctrl_q & ~wmask) | (w_data_q & wmask))
                        & DW'(CTRL_MASK);
               if (w_strb_q[0] && w_data_q[CTRL_START]) begin
                  if (eng_busy) bresp_d = RESP_SLVERR;
                  else eng_start = 1'b1;
               end
            end
            (aw_idx_q == I_DIN):
               din_d = (din_q & ~wmask) | (w_data_q & wmask);
            (aw_idx_q == I_STATUS),
            (aw_idx_q == I_DOUT),
            wr_gp_hit: begin
            end
            default: bresp_d = RESP_SLVERR;
         endcase
      end
      if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d  = 1'b0;
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end

      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
         rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         live_q    <= 1'b0;
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         ctrl_q    <= '0;
         din_q     <= '0;
         for (int g = 0; g < NUM_GP; g++) gp_q[g] <= '0;
      end else begin
         live_q    <= live_d;
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         ctrl_q    <= ctrl_d;
         din_q     <= din_d;
         gp_q      <= gp_d;
      end
   end

   sh_reg_shift_engine #(.DW(DW)) u_engine (
      .clk   (S_AXI_ACLK),
      .rst   (S_AXI_ARESET),
      .start (eng_start),
      .din   (din_q),
      .amt   (ctrl_d[CTRL_AMT_LSB +: CTRL_AMT_W]),
      .dir   (ctrl_d[CTRL_DIR]),
      .rot   (ctrl_d[CTRL_ROT]),
      .busy  (eng_busy),
      .done  (eng_done),
      .dout  (eng_dout)
   );

endmodule

// File: tb/tb_sh_reg_axil_shifter.sv
// Randomised bench for sh_reg_axil_shifter against an arithmetic
// reference of the register map and shift/rotate results.
module tb_sh_reg_axil_shifter;

   localparam int NG = 4;
   localparam logic [5:0] A_CTRL = 6'h00;
   localparam logic [5:0] A_STAT = 6'h04;
   localparam logic [5:0] A_DIN  = 6'h08;
   localparam logic [5:0] A_DOUT = 6'h0C;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [5:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        irq;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int b_cyc = 0;
   int irq_rise = -1;
   logic irq_prev = 1'b0;

   logic [31:0] gp_m [NG];
   logic [31:0] din_m;

   sh_reg_axil_shifter dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (irq && !irq_prev) irq_rise = cyc;
      irq_prev = irq;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                             input int amt,
                                             input bit dir, input bit rot);
      int r;
      if (!rot) begin
         if (amt >= 32) return 32'h0;
         return dir ? (d >> amt) : (d << amt);
      end
      r = amt % 32;
      if (r == 0) return d;
      return dir ? ((d >> r) | (d << (32 - r)))
                 : ((d << r) | (d >> (32 - r)));
   endfunction

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n;
      bit aw_hs, w_hs;
      @(negedge clk);
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      bready = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         n++;
         if (aw_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
      end
      while (!bvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bvalid_seen", 64'(bvalid), 64'(1));
      b_cyc = cyc;
      resp = bresp;
      @(negedge clk);
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      while (!rvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rvalid_seen", 64'(rvalid), 64'(1));
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic reset_checks();
      chk("rst_awready", 64'(awready), 64'(0));
      chk("rst_wready", 64'(wready), 64'(0));
      chk("rst_arready", 64'(arready), 64'(0));
      chk("rst_bvalid", 64'(bvalid), 64'(0));
      chk("rst_rvalid", 64'(rvalid), 64'(0));
      chk("rst_bresp", 64'(bresp), 64'(0));
      chk("rst_rresp", 64'(rresp), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_irq", 64'(irq), 64'(0));
   endtask

   task automatic wait_irq(input int limit);
      int n;
      n = 0;
      while (irq_rise < 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input logic [31:0] d, input int amt,
                         input bit dir, input bit rot);
      logic [1:0]  r;
      logic [31:0] v, ctrl;
      int t0;
      axi_write(A_DIN, d, 4'hF, r);
      din_m = d;
      chk("din_resp", 64'(r), 64'(OKAY));
      ctrl = (32'(amt) << 8) | 32'h8 | (32'(rot) << 2) | (32'(dir) << 1) | 32'h1;
      irq_rise = -1;
      axi_write(A_CTRL, ctrl, 4'hF, r);
      t0 = b_cyc;
      chk("ctrl_resp", 64'(r), 64'(OKAY));
      wait_irq(400);
      chk("op_latency", 64'(irq_rise - t0), 64'((amt == 0) ? 1 : amt));
      axi_read(A_DOUT, v, r);
      chk("dout", 64'(v), 64'(ref_shift(d, amt, dir, rot)));
      axi_read(A_STAT, v, r);
      chk("status_done", 64'(v), 64'(2));
      axi_read(A_CTRL, v, r);
      chk("ctrl_rb", 64'(v), 64'(ctrl & 32'hFF0E));
   endtask

   initial begin
      logic [1:0]  r, rr;
      logic [31:0] v, d, rv;
      int k, n, t0;
      logic [3:0]  s;

      for (int i = 0; i < NG; i++) gp_m[i] = '0;
      din_m = '0;
      repeat (3) @(negedge clk);
      reset_checks();
      rst = 1'b0;

      for (int i = 0; i < NG; i++) begin
         axi_write(6'(16 + 4 * i), 32'(i + 1), 4'hF, r);
         gp_m[i] = 32'(i + 1);
         chk("gp_wr_resp", 64'(r), 64'(OKAY));
      end
      for (int i = 0; i < NG; i++) begin
         axi_read(6'(16 + 4 * i), v, r);
         chk("gp_rd", 64'(v), 64'(gp_m[i]));
         chk("gp_rd_resp", 64'(r), 64'(OKAY));
      end

      // Interrupt disabled: done must appear in STATUS without irq.
      axi_write(A_DIN, 32'h0000_00F0, 4'hF, r);
      din_m = 32'h0000_00F0;
      axi_write(A_CTRL, 32'h0000_0403, 4'hF, r);
      n = 0;
      v = '0;
      while (v[1] == 1'b0 && n < 20) begin
         axi_read(A_STAT, v, r);
         n++;
      end
      chk("noie_status", 64'(v), 64'(2));
      chk("noie_irq", 64'(irq), 64'(0));
      axi_read(A_DOUT, v, r);
      chk("noie_dout", 64'(v), 64'(32'h0000_000F));

      run_op(32'h0000_00F0, 4, 1'b1, 1'b0);
      run_op(32'h8000_0001, 1, 1'b0, 1'b1);
      run_op(32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32, 1'b0, 1'b0);
      run_op(32'h1234_5678, 33, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         run_op($urandom, int'($urandom_range(0, 70)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Start while busy: rejected, running op keeps its loaded operands.
      d = $urandom;
      axi_write(A_DIN, d, 4'hF, r);
      din_m = d;
      irq_rise = -1;
      axi_write(A_CTRL, 32'h0000_C80D, 4'hF, r);
      t0 = b_cyc;
      axi_read(A_STAT, v, rr);
      chk("busy_status", 64'(v), 64'(1));
      axi_write(A_DIN, ~d, 4'hF, r);
      din_m = ~d;
      axi_write(A_CTRL, 32'h0000_050B, 4'hF, r);
      chk("busy_start_resp", 64'(r), 64'(SLVERR));
      wait_irq(400);
      chk("busy_latency", 64'(irq_rise - t0), 64'(200));
      axi_read(A_DOUT, v, r);
      chk("busy_dout", 64'(v), 64'(ref_shift(d, 200, 1'b0, 1'b1)));
      axi_read(A_CTRL, v, r);
      chk("busy_ctrl_rb", 64'(v), 64'(32'h0000_050A));

      axi_write(A_DIN, 32'h0, 4'hF, r);
      axi_write(A_DIN, 32'hFFFF_FFFF, 4'b0010, r);
      din_m = merge(32'h0, 32'hFFFF_FFFF, 4'b0010);
      axi_read(A_DIN, v, r);
      chk("din_strb", 64'(v), 64'(din_m));

      axi_read(6'h3C, v, r);
      chk("unmap_rdata", 64'(v), 64'(0));
      chk("unmap_rresp", 64'(r), 64'(SLVERR));
      axi_read(6'h30, v, r);
      chk("unmap30_rresp", 64'(r), 64'(SLVERR));
      axi_write(6'h3C, 32'h1234, 4'hF, r);
      chk("unmap_bresp", 64'(r), 64'(SLVERR));

      for (int i = 0; i < 16; i++) begin
         k = int'($urandom_range(0, NG - 1));
         d = $urandom;
         s = 4'($urandom);
         axi_write(6'(16 + 4 * k), d, s, r);
         gp_m[k] = merge(gp_m[k], d, s);
         k = int'($urandom_range(0, NG - 1));
         axi_read(6'(16 + 4 * k), v, r);
         chk("gp_rand", 64'(v), 64'(gp_m[k]));
      end

      // W leads AW by two cycles, B held off, read overlapping.
      fork
         begin
            n = 0;
            @(negedge clk);
            wdata = 32'hA5A5_5A5A; wstrb = 4'hF; wvalid = 1'b1;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
            wvalid = 1'b0;
            @(negedge clk);
            awaddr = 6'h18; awvalid = 1'b1;
            while (!awready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
            awvalid = 1'b0;
            while (!bvalid && n < 50) begin @(negedge clk); n++; end
            for (int i = 0; i < 5; i++) begin
               chk("hold_bvalid", 64'(bvalid), 64'(1));
               chk("hold_bresp", 64'(bresp), 64'(OKAY));
               chk("hold_awready", 64'(awready), 64'(0));
               @(negedge clk);
            end
            bready = 1'b1;
            @(negedge clk);
            bready = 1'b0;
            chk("b_released", 64'(bvalid), 64'(0));
            chk("aw_reopen", 64'(awready), 64'(1));
            gp_m[2] = 32'hA5A5_5A5A;
         end
         begin
            axi_read(A_DIN, rv, rr);
         end
      join
      chk("ovl_read", 64'(rv), 64'(din_m));
      axi_read(6'h18, v, r);
      chk("ovl_gp2", 64'(v), 64'(gp_m[2]));
      axi_read(6'h14, v, r);
      chk("ovl_gp1", 64'(v), 64'(gp_m[1]));

      // Reset in the middle of a long shift.
      axi_write(A_DIN, 32'h0F0F_0F0F, 4'hF, r);
      axi_write(A_CTRL, 32'h0000_C80F, 4'hF, r);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      reset_checks();
      rst = 1'b0;
      irq_rise = -1;
      axi_read(A_STAT, v, r);
      chk("post_rst_status", 64'(v), 64'(0));
      axi_read(A_DOUT, v, r);
      chk("post_rst_dout", 64'(v), 64'(0));
      axi_read(A_DIN, v, r);
      chk("post_rst_din", 64'(v), 64'(0));
      axi_read(A_CTRL, v, r);
      chk("post_rst_ctrl", 64'(v), 64'(0));
      axi_read(6'h10, v, r);
      chk("post_rst_gp0", 64'(v), 64'(0));
      repeat (250) @(negedge clk);
      chk("post_rst_no_irq", 64'(irq_rise), 64'(-1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
